// File: rtl/evaluador_banderas.sv
// NZCV flag register with a condition-code evaluator behind valid/ready handshakes.
// Define BANDERAS_FWD_EN to forward banderas_in into same-cycle requests instead of stalling.
module evaluador_banderas #(
  parameter int         TAG_W     = 4,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             banderas_we,
  input  logic [3:0]       banderas_in,
  input  logic             cond_valid,
  output logic             cond_ready,
  input  logic [3:0]       cond,
  input  logic [TAG_W-1:0] cond_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [TAG_W-1:0] res_tag,
  output logic [3:0]       banderas_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       banderas_d;
  logic [3:0]       cond_q, cond_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_taken_q, res_taken_d;
  logic             res_valid_q, res_valid_d;
  logic             ready_s;
  logic             accept_s;

  // Flag word f is {N,Z,C,V}.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'd0:    eval_cond = z;
      4'd1:    eval_cond = !z;
      4'd2:    eval_cond = cy;
      4'd3:    eval_cond = !cy;
      4'd4:    eval_cond = n;
      4'd5:    eval_cond = !n;
      4'd6:    eval_cond = v;
      4'd7:    eval_cond = !v;
      4'd8:    eval_cond = cy & !z;
      4'd9:    eval_cond = !cy | z;
      4'd10:   eval_cond = (n == v);
      4'd11:   eval_cond = (n != v);
      4'd12:   eval_cond = !z & (n == v);
      4'd13:   eval_cond = z | (n != v);
      4'd14:   eval_cond = 1'b1;
      4'd15:   eval_cond = 1'b0;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  // Next-state, flag update and handshake logic.
  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    tag_d       = tag_q;
    res_taken_d = res_taken_q;
    res_tag_d   = res_tag_q;
    ready_s     = 1'b0;

    if (banderas_we) begin
      banderas_d = banderas_in;
    end else begin
      banderas_d = banderas_q;
    end

    case (state_q)
      IDLE:    ready_s = 1'b1;
      STALL:   ready_s = 1'b0;
      HOLD:    ready_s = res_ready;
      default: ready_s = 1'b0;
    endcase
    accept_s = cond_valid & ready_s;

    case (state_q)
      IDLE, HOLD: begin
        if (accept_s) begin
`ifdef BANDERAS_FWD_EN
          // banderas_d already carries the forwarded value when a write is in flight.
          res_taken_d = eval_cond(cond, banderas_d);
          res_tag_d   = cond_tag;
          state_d     = HOLD;
`else
          if (banderas_we) begin
            cond_d  = cond;
            tag_d   = cond_tag;
            state_d = STALL;
          end else begin
            res_taken_d = eval_cond(cond, banderas_q);
            res_tag_d   = cond_tag;
            state_d     = HOLD;
          end
`endif
        end else if ((state_q == HOLD) && res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      STALL: begin
        // Wait until the flag register has stopped changing before evaluating.
        if (!banderas_we) begin
          res_taken_d = eval_cond(cond_q, banderas_q);
          res_tag_d   = tag_q;
          state_d     = HOLD;
        end else begin
          state_d = STALL;
        end
      end
      default: state_d = IDLE;
    endcase

    res_valid_d = (state_d == HOLD);

    if (rst) begin
      cond_ready = 1'b0;
    end else begin
      cond_ready = ready_s;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      banderas_q  <= FLAGS_RST;
      cond_q      <= 4'd0;
      tag_q       <= '0;
      res_tag_q   <= '0;
      res_taken_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      banderas_q  <= banderas_d;
      cond_q      <= cond_d;
      tag_q       <= tag_d;
      res_tag_q   <= res_tag_d;
      res_taken_q <= res_taken_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_taken = res_taken_q;
  assign res_tag   = res_tag_q;

endmodule

// File: tb/tb_evaluador_banderas.sv
// Directed bench for evaluador_banderas: condition tables, hazard interlock,
// backpressure, back-to-back throughput and mid-stream reset.
module tb_evaluador_banderas;

  logic       clk;
  logic       rst;
  logic       banderas_we;
  logic [3:0] banderas_in;
  logic       cond_valid;
  logic       cond_ready;
  logic [3:0] cond;
  logic [3:0] cond_tag;
  logic       res_valid;
  logic       res_ready;
  logic       res_taken;
  logic [3:0] res_tag;
  logic [3:0] banderas_q;

  logic       cond_ready2;
  logic       res_valid2;
  logic       res_taken2;
  logic [3:0] res_tag2;
  logic [3:0] banderas_q2;

  int tests_run = 0;
  int tests_failed = 0;

  evaluador_banderas #(.TAG_W(4), .FLAGS_RST(4'b0000)) u_dut (
    .clk(clk), .rst(rst), .banderas_we(banderas_we), .banderas_in(banderas_in),
    .cond_valid(cond_valid), .cond_ready(cond_ready), .cond(cond), .cond_tag(cond_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_tag(res_tag), .banderas_q(banderas_q)
  );

  evaluador_banderas #(.TAG_W(4), .FLAGS_RST(4'b0100)) u_dut_rst (
    .clk(clk), .rst(rst), .banderas_we(1'b0), .banderas_in(4'b0000),
    .cond_valid(1'b0), .cond_ready(cond_ready2), .cond(4'b0000), .cond_tag(4'b0000),
    .res_valid(res_valid2), .res_ready(1'b1), .res_taken(res_taken2),
    .res_tag(res_tag2), .banderas_q(banderas_q2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input logic [3:0] f);
    banderas_we = 1'b1;
    banderas_in = f;
    step();
    banderas_we = 1'b0;
    check_val("flag_write", 32'(banderas_q), 32'(f));
  endtask

  // Issue all 16 codes back-to-back; exp[i] is the hand-derived result for code i.
  task automatic run_table(input logic [3:0] f, input logic [15:0] exp);
    write_flags(f);
    for (int i = 0; i < 16; i++) begin
      cond_valid = 1'b1;
      cond       = 4'(i);
      cond_tag   = 4'(i);
      step();
      check_val($sformatf("tbl_%b_valid_%0d", f, i), 32'(res_valid), 32'd1);
      check_val($sformatf("tbl_%b_taken_%0d", f, i), 32'(res_taken), 32'(exp[i]));
      check_val($sformatf("tbl_%b_tag_%0d", f, i), 32'(res_tag), 32'(i));
    end
    cond_valid = 1'b0;
    step();
    check_val("tbl_drain_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    banderas_we = 1'b0;
    banderas_in = 4'b0000;
    cond_valid  = 1'b0;
    cond        = 4'd0;
    cond_tag    = 4'd0;
    res_ready   = 1'b1;
    step();
    step();
    check_val("rst_cond_ready", 32'(cond_ready), 32'd0);
    check_val("rst_banderas", 32'(banderas_q), 32'd0);
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_res_taken", 32'(res_taken), 32'd0);
    check_val("rst_res_tag", 32'(res_tag), 32'd0);
    check_val("rst_banderas_param", 32'(banderas_q2), 32'd4);
    rst = 1'b0;
    #1;
    check_val("idle_cond_ready", 32'(cond_ready), 32'd1);

    // Z only; N=1,V=1; C only.
    run_table(4'b0100, 16'h66A9);
    run_table(4'b1001, 16'h565A);
    run_table(4'b0010, 16'h55A6);

    // Same-cycle flag write and request.
    write_flags(4'b0000);
    banderas_we = 1'b1;
    banderas_in = 4'b0100;
    cond_valid  = 1'b1;
    cond        = 4'd0;
    cond_tag    = 4'd5;
    #1;
    check_val("hz_ready_idle", 32'(cond_ready), 32'd1);
    step();
    banderas_we = 1'b0;
    cond_valid  = 1'b0;
    #1;
`ifdef BANDERAS_FWD_EN
    check_val("hz_fwd_valid", 32'(res_valid), 32'd1);
    check_val("hz_fwd_taken", 32'(res_taken), 32'd1);
    check_val("hz_fwd_tag", 32'(res_tag), 32'd5);
`else
    check_val("hz_stall_valid", 32'(res_valid), 32'd0);
    check_val("hz_stall_ready", 32'(cond_ready), 32'd0);
    step();
    check_val("hz_valid", 32'(res_valid), 32'd1);
    check_val("hz_taken", 32'(res_taken), 32'd1);
    check_val("hz_tag", 32'(res_tag), 32'd5);
`endif
    step();
    check_val("hz_drain_valid", 32'(res_valid), 32'd0);

`ifndef BANDERAS_FWD_EN
    // A second write during STALL extends it by one cycle; last write wins.
    banderas_we = 1'b1;
    banderas_in = 4'b0000;
    cond_valid  = 1'b1;
    cond        = 4'd0;
    cond_tag    = 4'd6;
    step();
    cond_valid  = 1'b0;
    banderas_in = 4'b0100;
    step();
    check_val("hz2_still_stalled", 32'(res_valid), 32'd0);
    banderas_we = 1'b0;
    step();
    check_val("hz2_valid", 32'(res_valid), 32'd1);
    check_val("hz2_taken", 32'(res_taken), 32'd1);
    check_val("hz2_tag", 32'(res_tag), 32'd6);
    step();
    check_val("hz2_drain_valid", 32'(res_valid), 32'd0);
`endif

    // Backpressure with a flag change while the result is held.
    write_flags(4'b0100);
    res_ready  = 1'b0;
    cond_valid = 1'b1;
    cond       = 4'd0;
    cond_tag   = 4'd7;
    step();
    cond_valid  = 1'b0;
    banderas_we = 1'b1;
    banderas_in = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val($sformatf("bp_valid_%0d", k), 32'(res_valid), 32'd1);
      check_val($sformatf("bp_taken_%0d", k), 32'(res_taken), 32'd1);
      check_val($sformatf("bp_tag_%0d", k), 32'(res_tag), 32'd7);
      check_val($sformatf("bp_ready_%0d", k), 32'(cond_ready), 32'd0);
      step();
      banderas_we = 1'b0;
    end
    check_val("bp_banderas", 32'(banderas_q), 32'd0);
    res_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 32'(cond_ready), 32'd1);
    step();
    check_val("bp_consumed", 32'(res_valid), 32'd0);
    step();
    check_val("bp_once", 32'(res_valid), 32'd0);

    // Back-to-back tags 1..4, then reset mid-stream.
    write_flags(4'b1001);
    for (int i = 1; i <= 4; i++) begin
      cond_valid = 1'b1;
      cond       = 4'd14;
      cond_tag   = 4'(i);
      step();
      check_val($sformatf("b2b_valid_%0d", i), 32'(res_valid), 32'd1);
      check_val($sformatf("b2b_taken_%0d", i), 32'(res_taken), 32'd1);
      check_val($sformatf("b2b_tag_%0d", i), 32'(res_tag), 32'(i));
    end
    cond     = 4'd15;
    cond_tag = 4'd9;
    rst      = 1'b1;
    #1;
    check_val("mid_rst_ready", 32'(cond_ready), 32'd0);
    step();
    check_val("mid_rst_valid", 32'(res_valid), 32'd0);
    check_val("mid_rst_tag", 32'(res_tag), 32'd0);
    check_val("mid_rst_taken", 32'(res_taken), 32'd0);
    check_val("mid_rst_banderas", 32'(banderas_q), 32'd0);
    check_val("mid_rst_banderas_param", 32'(banderas_q2), 32'd4);
    rst        = 1'b0;
    cond_valid = 1'b0;
    step();
    check_val("post_rst_valid_a", 32'(res_valid), 32'd0);
    step();
    check_val("post_rst_valid_b", 32'(res_valid), 32'd0);
    cond_valid = 1'b1;
    cond       = 4'd14;
    cond_tag   = 4'd2;
    step();
    cond_valid = 1'b0;
    check_val("post_rst_req_valid", 32'(res_valid), 32'd1);
    check_val("post_rst_req_tag", 32'(res_tag), 32'd2);
    step();
    check_val("post_rst_drain", 32'(res_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/evaluador_banderas.md
Name: evaluador_banderas

Overview:
- Consumer side of the ALU flag interface: latches the 4-bit NZCV flag word produced by the arithmetic units (subtract, add), then evaluates 4-bit branch/predication condition codes against the latched flags.
- Sits between the ALU and the fetch/branch control in the CPU pipeline.
- Valid/ready handshake on both the request and result sides, plus a read-after-write hazard interlock on the flag register.

Parameters:
- TAG_W, 4, width of the request tag carried unchanged from request to result.
- FLAGS_RST, 4'b0000, reset value of the flag register {N,Z,C,V}.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- banderas_we  input  1  write strobe for the flag register.
- banderas_in  input  4  flag word from ALU: [3]=N, [2]=Z, [1]=C, [0]=V.
- cond_valid  input  1  condition request valid.
- cond_ready  output  1  block can accept a request this cycle.
- cond  input  4  condition code.
- cond_tag  input  TAG_W  request tag.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts result.
- res_taken  output  1  1 = condition true.
- res_tag  output  TAG_W  tag of the evaluated request.
- banderas_q  output  4  current flag register contents.

Behaviour:
- Reset (rst=1 at clk edge): banderas_q=FLAGS_RST, state=IDLE, res_valid=0, res_taken=0, res_tag=0, cond_ready=0 during the reset cycle, then 1 in IDLE. Reset mid-operation discards any held or stalled request.
- Flag register: on banderas_we=1, banderas_q <= banderas_in next edge, in any state. Multiple consecutive writes: the last one wins.
- Condition codes, evaluated on the flag value F:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0
- FSM states: IDLE, STALL, HOLD.
  - IDLE: cond_ready=1. If cond_valid & !banderas_we: capture cond/tag, evaluate against banderas_q, go to HOLD with res_valid=1 next cycle (latency 1).
  - IDLE, cond_valid & banderas_we on the same cycle (hazard): capture cond/tag, go to STALL; no result that cycle.
  - STALL: cond_ready=0. Evaluate against the now-updated banderas_q, go to HOLD (latency 2). If banderas_we is asserted again in STALL, remain in STALL one more cycle.
  - HOLD: res_valid=1; res_taken and res_tag stable until res_ready=1.
    - res_ready=1 and cond_valid=1: cond_ready=1 back-to-back; the new request follows the same hazard rule and the result updates next cycle.
    - res_ready=1 and no new request: go to IDLE, res_valid=0 next cycle.
  - cond_ready in HOLD = res_ready.
- A flag write during HOLD does not alter the held result.
- Throughput: 1 result/cycle when there is no hazard and no backpressure.

Optional Feature:
- BANDERAS_FWD_EN defined: when banderas_we and the request are accepted in the same cycle, evaluate directly against banderas_in (forwarding). STALL is never entered; latency is always 1.
- Undefined: the interlock via STALL described above applies.

Test Plan:
- Reset -> banderas_q=0000, res_valid=0, cond_ready=1 the cycle after rst deasserts; write FLAGS_RST=4'b0100, reset again -> banderas_q=0100.
- Write banderas=0100 (Z), then cond=0 EQ tag=3 -> next cycle res_valid=1, res_taken=1, res_tag=3; cond=1 NE -> res_taken=0.
- banderas=1001 (N=1,V=1): GE -> 1, LT -> 0, GT -> 1, LE -> 0; AL -> 1, NV -> 0 for any flags.
- Same-cycle banderas_we=1 (banderas_in=0100, old=0000) with cond=EQ -> without macro: res_valid at +2 cycles, res_taken=1, cond_ready=0 for one cycle; with BANDERAS_FWD_EN: res_valid at +1, res_taken=1.
- Backpressure: res_ready=0 for 3 cycles while banderas changes to 0000 -> res_taken/res_tag unchanged, cond_ready=0; on res_ready=1 the result is consumed exactly once.
- Back-to-back requests with tags 1,2,3,4, res_ready=1 -> four consecutive result cycles, tags in order; assert rst mid-stream -> res_valid=0 next cycle and no stale result afterwards.
